// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(
  parameter int DATA_W = 12
);
  logic                     i_valid;
  logic                     o_ready;
  logic signed [DATA_W-1:0] i_data_a;
  logic signed [DATA_W-1:0] i_data_b;
  logic [2:0]               i_inst;
  logic                     i_acc_clr;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_overflow;

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_inst, i_acc_clr, i_ready,
    output o_ready, o_valid, o_data, o_overflow
  );

  modport master (
    output i_valid, i_data_a, i_data_b, i_inst, i_acc_clr, i_ready,
    input  o_ready, o_valid, o_data, o_overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage signed fixed-point ALU with MAC accumulator and valid/ready flow
module alu_pipe #(
  parameter int DATA_W = 12,
  parameter int FRAC_W = 5,
  parameter int ACC_W  = 24,
  parameter int SAT_EN = 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  alu_pipe_if.slave bus
);
  // Working width holds a full product or the accumulator plus headroom for the add.
  localparam int WW = ((ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W) + 2;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_MAC    = 3'd3;
  localparam logic [2:0] OP_XNOR   = 3'd4;
  localparam logic [2:0] OP_RELU   = 3'd5;
  localparam logic [2:0] OP_MEAN   = 3'd6;
  localparam logic [2:0] OP_ABSMAX = 3'd7;

  localparam logic signed [WW-1:0] D_MAX = {{(WW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [WW-1:0] D_MIN = ~D_MAX;
  localparam logic signed [WW-1:0] A_MAX = {{(WW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [WW-1:0] A_MIN = ~A_MAX;
  localparam logic signed [WW-1:0] RND   = {{(WW - 1){1'b0}}, 1'b1} << (FRAC_W - 1);

  logic                     en;
  logic                     s1_valid_q;
  logic signed [DATA_W-1:0] a_q;
  logic signed [DATA_W-1:0] b_q;
  logic [2:0]               inst_q;
  logic                     clr_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_ovf_q;

  logic signed [WW-1:0]     a_w;
  logic signed [WW-1:0]     b_w;
  logic signed [WW-1:0]     prod_r;
  logic signed [WW-1:0]     acc_base;
  logic signed [WW-1:0]     acc_sum;
  logic signed [WW-1:0]     acc_d;
  logic signed [WW-1:0]     abs_a;
  logic signed [WW-1:0]     abs_b;
  logic signed [WW-1:0]     val;
  logic signed [DATA_W-1:0] xnor_v;
  logic signed [DATA_W-1:0] res_d;
  logic                     ovf_d;

  assign en             = !out_valid_q || bus.i_ready;
  assign bus.o_ready    = en;
  assign bus.o_valid    = out_valid_q;
  assign bus.o_data     = out_data_q;
  assign bus.o_overflow = out_ovf_q;

  always_comb begin
    a_w      = WW'(a_q);
    b_w      = WW'(b_q);
    prod_r   = ((a_w * b_w) + RND) >>> FRAC_W;
    acc_base = clr_q ? D_MAX ^ D_MAX : WW'(acc_q);
    acc_sum  = acc_base + prod_r;
    acc_d    = acc_sum;
    if (acc_sum > A_MAX) begin
      acc_d = A_MAX;
    end else if (acc_sum < A_MIN) begin
      acc_d = A_MIN;
    end
    abs_a  = (a_w < 0) ? -a_w : a_w;
    abs_b  = (b_w < 0) ? -b_w : b_w;
    xnor_v = ~(a_q ^ b_q);

    // Every op lands in the wide domain so one range check covers all overflow cases.
    val = '0;
    case (inst_q)
      OP_ADD:    val = a_w + b_w;
      OP_SUB:    val = a_w - b_w;
      OP_MUL:    val = prod_r;
      OP_MAC:    val = acc_d;
      OP_XNOR:   val = WW'(xnor_v);
      OP_RELU:   val = (a_w < 0) ? '0 : a_w;
      OP_MEAN:   val = (a_w + b_w) >>> 1;
      OP_ABSMAX: val = (abs_a > abs_b) ? abs_a : abs_b;
      default:   val = '0;
    endcase

    ovf_d = (val > D_MAX) || (val < D_MIN);
    res_d = val[DATA_W-1:0];
    if ((SAT_EN != 0) && ovf_d) begin
      res_d = val[WW-1] ? D_MIN[DATA_W-1:0] : D_MAX[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      inst_q      <= '0;
      clr_q       <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= bus.i_valid;
      a_q         <= bus.i_data_a;
      b_q         <= bus.i_data_b;
      inst_q      <= bus.i_inst;
      clr_q       <= bus.i_valid && bus.i_acc_clr;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= res_d;
        out_ovf_q  <= ovf_d;
        if (inst_q == OP_MAC) begin
          acc_q <= acc_d[ACC_W-1:0];
        end else if (clr_q) begin
          acc_q <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe against an integer reference model
module tb_alu_pipe;
  localparam int DW = 12;
  localparam int FW = 5;
  localparam int AW = 24;

  typedef struct {
    int sat;
    int wrap;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 vld;
  logic                 rdy;
  logic signed [DW-1:0] va;
  logic signed [DW-1:0] vb;
  logic [2:0]           vinst;
  logic                 vclr;

  alu_pipe_if #(.DATA_W(DW)) bus_s ();
  alu_pipe_if #(.DATA_W(DW)) bus_w ();

  assign bus_s.i_valid   = vld;
  assign bus_s.i_ready   = rdy;
  assign bus_s.i_data_a  = va;
  assign bus_s.i_data_b  = vb;
  assign bus_s.i_inst    = vinst;
  assign bus_s.i_acc_clr = vclr;
  assign bus_w.i_valid   = vld;
  assign bus_w.i_ready   = rdy;
  assign bus_w.i_data_a  = va;
  assign bus_w.i_data_b  = vb;
  assign bus_w.i_inst    = vinst;
  assign bus_w.i_acc_clr = vclr;

  alu_pipe #(.DATA_W(DW), .FRAC_W(FW), .ACC_W(AW), .SAT_EN(1)) dut_s (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_s)
  );

  alu_pipe #(.DATA_W(DW), .FRAC_W(FW), .ACC_W(AW), .SAT_EN(0)) dut_w (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_w)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  exp_t   exp_q[$];
  int     got_q[$];
  longint macc = 0;
  bit     hold_pending = 0;
  int     hold_data = 0;
  int     hold_ovf = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int op, input int a, input int b, input bit c,
                                output exp_t e);
    longint v, r, s, amax, dmax;
    int w;
    amax = (longint'(1) <<< (AW - 1)) - 1;
    dmax = (longint'(1) <<< (DW - 1)) - 1;
    r = (longint'(a) * longint'(b) + (longint'(1) <<< (FW - 1))) >>> FW;
    v = 0;
    case (op)
      0: v = longint'(a) + b;
      1: v = longint'(a) - b;
      2: v = r;
      3: begin
        s = (c ? 0 : macc) + r;
        if (s > amax) s = amax;
        if (s < -amax - 1) s = -amax - 1;
        macc = s;
        v = s;
      end
      4: v = ~(a ^ b);
      5: v = (a < 0) ? 0 : a;
      6: v = (longint'(a) + b) >>> 1;
      default: v = ((a < 0 ? -a : a) > (b < 0 ? -b : b)) ? (a < 0 ? -a : a) : (b < 0 ? -b : b);
    endcase
    if (op != 3 && c) macc = 0;
    e.ovf = (v > dmax || v < -dmax - 1) ? 1 : 0;
    e.sat = (v > dmax) ? int'(dmax) : (v < -dmax - 1) ? int'(-dmax - 1) : int'(v);
    w = int'(v & ((longint'(1) <<< DW) - 1));
    if (w > dmax) w = w - (1 << DW);
    e.wrap = w;
  endfunction

  task automatic tick(output bit accepted);
    exp_t e;
    accepted = 1'b0;
    #1;
    if (rst_n) begin
      if (hold_pending) begin
        chk("hold_data", int'(bus_s.o_data), hold_data);
        chk("hold_ovf", int'(bus_s.o_overflow), hold_ovf);
      end
      if (bus_s.o_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_sat", int'(bus_s.o_data), e.sat);
          chk("ovf_sat", int'(bus_s.o_overflow), e.ovf);
          chk("data_wrap", int'(bus_w.o_data), e.wrap);
          chk("ovf_wrap", int'(bus_w.o_overflow), e.ovf);
          got_q.push_back(int'(bus_s.o_data));
        end
      end
      hold_pending = bus_s.o_valid && !rdy;
      hold_data    = int'(bus_s.o_data);
      hold_ovf     = int'(bus_s.o_overflow);
      if (vld && bus_s.o_ready) begin
        accepted = 1'b1;
        model(int'(vinst), int'(va), int'(vb), vclr, e);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      macc = 0;
      hold_pending = 0;
    end
    @(negedge clk);
  endtask

  task automatic send(input int op, input int a, input int b, input bit c);
    bit ok;
    vld = 1'b1;
    rdy = 1'b1;
    vinst = op[2:0];
    va = a[DW-1:0];
    vb = b[DW-1:0];
    vclr = c;
    tick(ok);
    if (!ok) chk("send_accept", 0, 1);
    vld = 1'b0;
    vclr = 1'b0;
  endtask

  task automatic drain();
    bit d;
    vld = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(d);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick(d);
  endtask

  function automatic int gq(input int i);
    return (got_q.size() > i) ? got_q[i] : 99999;
  endfunction

  function automatic int rnd_operand();
    case ($urandom_range(0, 7))
      0: return -2048;
      1: return 2047;
      2: return 0;
      3: return $urandom_range(0, 64) - 32;
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  initial begin
    bit acc;
    int k;
    rst_n = 1'b0;
    vld = 1'b0; rdy = 1'b1; va = '0; vb = '0; vinst = '0; vclr = 1'b0;
    @(negedge clk);
    tick(acc);
    tick(acc);
    chk("rst_valid", int'(bus_s.o_valid), 0);
    chk("rst_data", int'(bus_s.o_data), 0);
    chk("rst_ovf", int'(bus_s.o_overflow), 0);
    rst_n = 1'b1;

    // T1 add overflow and normal add
    got_q.delete();
    send(0, 2047, 1, 0);
    send(0, 100, -30, 0);
    drain();
    chk("T1_add_sat", gq(0), 2047);
    chk("T1_add_norm", gq(1), 70);

    // T2 multiply rounding and saturation
    got_q.delete();
    send(2, 32, 48, 0);
    send(2, 1, 16, 0);
    send(2, 2047, 2047, 0);
    drain();
    chk("T2_mul_1p5", gq(0), 48);
    chk("T2_mul_half", gq(1), 1);
    chk("T2_mul_sat", gq(2), 2047);

    // T3 back-to-back MAC accumulation
    got_q.delete();
    send(3, 32, 32, 1);
    send(3, 32, 32, 0);
    send(3, 32, 32, 0);
    send(3, 32, 32, 0);
    send(3, 64, 32, 1);
    drain();
    chk("T3_mac0", gq(0), 32);
    chk("T3_mac1", gq(1), 64);
    chk("T3_mac2", gq(2), 96);
    chk("T3_mac3", gq(3), 128);
    chk("T3_mac_clr", gq(4), 64);

    // T4 large MACs, accumulator saturation and recovery
    got_q.delete();
    send(3, 2047, 2047, 1);
    send(3, 2047, 2047, 0);
    send(3, -2047, 2047, 0);
    for (int i = 0; i < 70; i++) send(3, -2048, -2048, i == 0);
    send(3, -2048, 2047, 0);
    send(4, 5, 3, 1);
    send(3, 32, 32, 0);
    drain();
    chk("T4_mac_big", gq(0), 2047);
    chk("T4_clr_by_nonmac", gq(75), 32);

    // T5 backpressure mid-stream
    got_q.delete();
    k = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (k >= 4 && exp_q.size() == 0) break;
      vld = (k < 4);
      vinst = 3'd0;
      vclr = 1'b0;
      va = DW'(k * 10);
      vb = DW'(k);
      rdy = !(cyc >= 2 && cyc <= 4);
      if (cyc >= 2 && cyc <= 4) begin
        #1;
        chk("T5_stall_ready", int'(bus_s.o_ready), 0);
        chk("T5_stall_valid", int'(bus_s.o_valid), 1);
      end
      tick(acc);
      if (acc) k++;
    end
    vld = 1'b0;
    drain();
    chk("T5_count", got_q.size(), 4);
    chk("T5_r0", gq(0), 0);
    chk("T5_r1", gq(1), 11);
    chk("T5_r2", gq(2), 22);
    chk("T5_r3", gq(3), 33);

    // T6 reset during stall with two ops in flight
    got_q.delete();
    rdy = 1'b0;
    vld = 1'b1; vinst = 3'd3; va = 12'sd64; vb = 12'sd64; vclr = 1'b1;
    tick(acc);
    vinst = 3'd0; va = 12'sd5; vb = 12'sd6; vclr = 1'b0;
    tick(acc);
    vld = 1'b0;
    tick(acc);
    rst_n = 1'b0;
    tick(acc);
    rst_n = 1'b1;
    chk("T6_valid", int'(bus_s.o_valid), 0);
    chk("T6_data", int'(bus_s.o_data), 0);
    chk("T6_valid_w", int'(bus_w.o_valid), 0);
    send(3, 32, 32, 0);
    drain();
    chk("T6_mac_after_rst", gq(0), 32);

    // randomized traffic with random backpressure
    for (int i = 0; i < 800; i++) begin
      vld = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      vinst = 3'($urandom_range(0, 7));
      va = DW'(rnd_operand());
      vb = DW'(rnd_operand());
      vclr = ($urandom_range(0, 9) == 0);
      tick(acc);
    end
    vclr = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
